countryroad_timer: RTL and testbench
====================================

COUNTRYROAD_TIMER -- requirements
Module: countryroad_timer

Interface
REQ-001 Parameter TICK_DIV, default 50000000, number of clk cycles per one-second tick (legal range 2 and above).
REQ-002 Parameter GREEN_DEF, default 30, reset value of the green duration register.
REQ-003 Parameter YELLOW_DEF, default 3, reset value of the yellow duration register.
REQ-004 Port clk, input, 1 bit: the single system clock; all state updates on the rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 Port start_n, input, 1 bit: one-cycle phase-restart strobe from the country-road light FSM.
REQ-007 Port light_r, input, 3 bits: one-hot current country-road light (100 green, 010 yellow, 001 red).
REQ-008 Port cfg_green, input, 6 bits: new green duration in seconds.
REQ-009 Port cfg_yellow, input, 6 bits: new yellow duration in seconds.
REQ-010 Port cfg_we, input, 1 bit: one-cycle write strobe for cfg_green and cfg_yellow.
REQ-011 Port green_time, output, 6 bits: remaining green seconds, registered.
REQ-012 Port yellow_time, output, 6 bits: remaining yellow seconds, registered.
REQ-013 Port tick, output, 1 bit: one-cycle pulse marking each one-second boundary.
REQ-014 Port cfg_err, output, 1 bit, registered: one-cycle pulse on a rejected configuration write.

Function
REQ-015 Prescaler counts 0 to TICK_DIV-1 and then wraps to 0; tick is high exactly while the prescaler equals TICK_DIV-1.
REQ-016 start_n high resets the prescaler to 0 on that edge, so the first second after any restart is a full TICK_DIV cycles.
REQ-017 start_n high with light_r==100 loads yellow_time from the yellow duration register and clears green_time to 0 on that edge.
REQ-018 start_n high with light_r==001 loads green_time from the green duration register and clears yellow_time to 0 on that edge.
REQ-019 start_n high with light_r==010 leaves both counters unchanged; the prescaler still resets.
REQ-020 Loaded values are visible on the outputs in the cycle after the start_n cycle (one-cycle latency).
REQ-021 With no start_n, when tick is high the counter of the active phase decrements by 1 if its value is above 1; the active phase is green_time for light_r 100 and yellow_time for light_r 010.
REQ-022 A counter at 1 holds at 1 on tick (saturating floor) and never reaches 0 by decrement.
REQ-023 With no start_n, a counter whose phase is not active is cleared to 0 on every edge.
REQ-024 Priority order is reset, then start_n load, then tick decrement, then the inactive-phase clear; start_n and tick in the same cycle yields the load only.
REQ-025 light_r not one-hot (000, 011, 101, 110, 111): both counters are cleared to 0 and start_n is ignored, except that the prescaler still resets on start_n.
REQ-026 cfg_we with cfg_green and cfg_yellow both non-zero updates both duration registers on that edge.
REQ-027 cfg_we with either cfg_green or cfg_yellow equal to zero leaves both registers unchanged and pulses cfg_err high for exactly the next cycle.
REQ-028 cfg_we and start_n in the same cycle: the load uses the pre-write duration values, and the new values apply from the next start_n onward.
REQ-029 All widths are 6 bits unsigned; there is no wrap below 0 and no carry beyond 63.

Reset
REQ-030 On rst_n low, asynchronously: prescaler=0, green_time=0, yellow_time=0, cfg_err=0, green duration register=GREEN_DEF, yellow duration register=YELLOW_DEF.
REQ-031 tick is 0 during reset, and the first tick occurs TICK_DIV cycles after rst_n deasserts.
REQ-032 Reset asserted mid-count abandons the count; after release both counters stay 0 until the next start_n.

Verification
REQ-033 TICK_DIV=4, defaults; light_r=001, start_n pulse -> green_time=30 next cycle; ticks every 4 cycles; 29 after the first tick.
REQ-034 Green counting from 2, two ticks -> values 1 then held at 1; then light_r=100 with a start_n pulse -> yellow_time=3 and green_time=0 next cycle.
REQ-035 light_r=010 and yellow_time=3 for 3 ticks -> 2, 1, 1; then light_r=001 -> yellow_time=0 on the next edge.
REQ-036 cfg_we with cfg_green=0 and cfg_yellow=5 -> cfg_err high for one cycle; the next green load is still 30.
REQ-037 cfg_we with 10/2 in the same cycle as start_n while light_r=001 -> load of 30; the next red restart loads 10.
REQ-038 rst_n pulsed low while green_time=17 -> outputs 0 immediately; no decrement until a new start_n loads.

Source files
------------

// File: rtl/countryroad_timer.sv
// Country-road phase timer: a one-second prescaler plus two 6-bit
// countdown registers (green and yellow) that are reloaded from
// programmable duration registers whenever the light FSM restarts a phase.
module countryroad_timer #(
  parameter int TICK_DIV   = 50000000,
  parameter int GREEN_DEF  = 30,
  parameter int YELLOW_DEF = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_n,
  input  logic [2:0] light_r,
  input  logic [5:0] cfg_green,
  input  logic [5:0] cfg_yellow,
  input  logic       cfg_we,
  output logic [5:0] green_time,
  output logic [5:0] yellow_time,
  output logic       tick,
  output logic       cfg_err
);

  // Prescaler width is sized to hold TICK_DIV-1; TICK_DIV is at least 2.
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  // One-hot encodings of the country-road light.
  localparam logic [2:0] LIGHT_GREEN  = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_RED    = 3'b001;

  localparam logic [5:0] GREEN_RST  = 6'(GREEN_DEF);
  localparam logic [5:0] YELLOW_RST = 6'(YELLOW_DEF);

  logic [PW-1:0] prescale_q, prescale_d;
  logic [5:0]    greenTime_q, greenTime_d;
  logic [5:0]    yellowTime_q, yellowTime_d;
  logic [5:0]    greenDur_q, greenDur_d;
  logic [5:0]    yellowDur_q, yellowDur_d;
  logic          cfgErr_q, cfgErr_d;

  logic          tickNow;
  logic          lightValid;
  logic          cfgReject;

  // The one-second boundary is the last prescaler count.
  always_comb begin
    tickNow = (prescale_q == PRE_MAX);
  end

  // Only the three legal one-hot light codes drive the counters.
  always_comb begin
    lightValid = (light_r == LIGHT_GREEN) ||
                 (light_r == LIGHT_YELLOW) ||
                 (light_r == LIGHT_RED);
  end

  // Prescaler restarts on a phase restart so the first second is full length.
  always_comb begin
    if (start_n || tickNow) begin
      prescale_d = '0;
    end else begin
      prescale_d = prescale_q + PW'(1);
    end
  end

  // Countdown registers: load on restart, decrement on tick, clear when idle.
  always_comb begin
    greenTime_d  = greenTime_q;
    yellowTime_d = yellowTime_q;
    if (!lightValid) begin
      greenTime_d  = '0;
      yellowTime_d = '0;
    end else if (start_n) begin
      case (light_r)
        LIGHT_GREEN: begin
          yellowTime_d = yellowDur_q;
          greenTime_d  = '0;
        end
        LIGHT_RED: begin
          greenTime_d  = greenDur_q;
          yellowTime_d = '0;
        end
        default: begin
          greenTime_d  = greenTime_q;
          yellowTime_d = yellowTime_q;
        end
      endcase
    end else begin
      if (light_r == LIGHT_GREEN) begin
        if (tickNow && (greenTime_q > 6'd1)) begin
          greenTime_d = greenTime_q - 6'd1;
        end
      end else begin
        greenTime_d = '0;
      end
      if (light_r == LIGHT_YELLOW) begin
        if (tickNow && (yellowTime_q > 6'd1)) begin
          yellowTime_d = yellowTime_q - 6'd1;
        end
      end else begin
        yellowTime_d = '0;
      end
    end
  end

  // A write with any zero duration is rejected as a whole and flagged.
  always_comb begin
    cfgReject   = cfg_we && ((cfg_green == 6'd0) || (cfg_yellow == 6'd0));
    greenDur_d  = greenDur_q;
    yellowDur_d = yellowDur_q;
    cfgErr_d    = cfgReject;
    if (cfg_we && !cfgReject) begin
      greenDur_d  = cfg_green;
      yellowDur_d = cfg_yellow;
    end
  end

  // State register for prescaler, counters, durations and error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale_q   <= '0;
      greenTime_q  <= '0;
      yellowTime_q <= '0;
      greenDur_q   <= GREEN_RST;
      yellowDur_q  <= YELLOW_RST;
      cfgErr_q     <= 1'b0;
    end else begin
      prescale_q   <= prescale_d;
      greenTime_q  <= greenTime_d;
      yellowTime_q <= yellowTime_d;
      greenDur_q   <= greenDur_d;
      yellowDur_q  <= yellowDur_d;
      cfgErr_q     <= cfgErr_d;
    end
  end

  assign green_time  = greenTime_q;
  assign yellow_time = yellowTime_q;
  assign tick        = tickNow;
  assign cfg_err     = cfgErr_q;

endmodule

// File: tb/tb_countryroad_timer.sv
// Self-checking bench for countryroad_timer: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the timer.
module tb_countryroad_timer;

  localparam int TD = 4;
  localparam int GDEF = 30;
  localparam int YDEF = 3;

  logic       clk;
  logic       rst_n;
  logic       start_n;
  logic [2:0] light_r;
  logic [5:0] cfg_green;
  logic [5:0] cfg_yellow;
  logic       cfg_we;
  logic [5:0] green_time;
  logic [5:0] yellow_time;
  logic       tick;
  logic       cfg_err;

  int total = 0;
  int bad = 0;

  // Behavioural model state: elapsed cycles since the last restart/reset,
  // remaining seconds and programmed durations as plain integers.
  int mCycles;
  int mGreen;
  int mYellow;
  int mGDur;
  int mYDur;
  int mErr;

  countryroad_timer #(
    .TICK_DIV  (TD),
    .GREEN_DEF (GDEF),
    .YELLOW_DEF(YDEF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_n    (start_n),
    .light_r    (light_r),
    .cfg_green  (cfg_green),
    .cfg_yellow (cfg_yellow),
    .cfg_we     (cfg_we),
    .green_time (green_time),
    .yellow_time(yellow_time),
    .tick       (tick),
    .cfg_err    (cfg_err)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int modelTick();
    return ((mCycles % TD) == TD - 1) ? 1 : 0;
  endfunction

  task automatic checkModel(input string tag);
    checkOutput({tag, "_green"}, 32'(green_time), 32'(mGreen));
    checkOutput({tag, "_yellow"}, 32'(yellow_time), 32'(mYellow));
    checkOutput({tag, "_tick"}, 32'(tick), 32'(modelTick()));
    checkOutput({tag, "_err"}, 32'(cfg_err), 32'(mErr));
  endtask

  // Drive one cycle of inputs, advance the model by one second-rule step,
  // then compare just after the clock edge.
  task automatic applyStimulus(input logic st, input logic [2:0] lt, input logic we,
                               input logic [5:0] cg, input logic [5:0] cy);
    int tk;
    bit oneHot;
    start_n    = st;
    light_r    = lt;
    cfg_we     = we;
    cfg_green  = cg;
    cfg_yellow = cy;
    tk = modelTick();
    oneHot = (lt == 3'b100) || (lt == 3'b010) || (lt == 3'b001);
    if (!oneHot) begin
      mGreen  = 0;
      mYellow = 0;
    end else if (st) begin
      if (lt == 3'b100) begin
        mYellow = mYDur;
        mGreen  = 0;
      end else if (lt == 3'b001) begin
        mGreen  = mGDur;
        mYellow = 0;
      end
    end else begin
      if (lt == 3'b100) mGreen = (tk == 1 && mGreen > 1) ? mGreen - 1 : mGreen;
      else mGreen = 0;
      if (lt == 3'b010) mYellow = (tk == 1 && mYellow > 1) ? mYellow - 1 : mYellow;
      else mYellow = 0;
    end
    mCycles = st ? 0 : mCycles + 1;
    if (we && (cg == 0 || cy == 0)) begin
      mErr = 1;
    end else begin
      mErr = 0;
      if (we) begin
        mGDur = int'(cg);
        mYDur = int'(cy);
      end
    end
    @(posedge clk);
    #1;
    checkModel("cyc");
  endtask

  task automatic idle(input logic [2:0] lt, input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, lt, 1'b0, 6'd0, 6'd0);
  endtask

  // Asynchronous reset in mid-cycle; outputs must clear without a clock edge.
  task automatic doReset();
    #2;
    rst_n      = 1'b0;
    start_n    = 1'b0;
    cfg_we     = 1'b0;
    cfg_green  = 6'd0;
    cfg_yellow = 6'd0;
    #1;
    mCycles = 0;
    mGreen  = 0;
    mYellow = 0;
    mGDur   = GDEF;
    mYDur   = YDEF;
    mErr    = 0;
    checkModel("rst_async");
    @(posedge clk);
    #1;
    checkModel("rst_held");
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    start_n    = 1'b0;
    light_r    = 3'b001;
    cfg_we     = 1'b0;
    cfg_green  = 6'd0;
    cfg_yellow = 6'd0;
    @(posedge clk);
    #1;
    doReset();

    // Red restart loads 30, then one tick every TD cycles.
    applyStimulus(1'b1, 3'b001, 1'b0, 6'd0, 6'd0);
    checkOutput("load30", 32'(green_time), 32'd30);
    idle(3'b100, 3);
    checkOutput("first_tick", 32'(tick), 32'd1);
    idle(3'b100, 1);
    checkOutput("green29", 32'(green_time), 32'd29);

    // Green from 2 saturates at 1, then a green restart loads yellow.
    applyStimulus(1'b0, 3'b100, 1'b1, 6'd2, 6'd3);
    applyStimulus(1'b1, 3'b001, 1'b0, 6'd0, 6'd0);
    checkOutput("load2", 32'(green_time), 32'd2);
    idle(3'b100, 4);
    checkOutput("green1", 32'(green_time), 32'd1);
    idle(3'b100, 4);
    checkOutput("green_hold1", 32'(green_time), 32'd1);
    applyStimulus(1'b1, 3'b100, 1'b0, 6'd0, 6'd0);
    checkOutput("yload3", 32'(yellow_time), 32'd3);
    checkOutput("gclear", 32'(green_time), 32'd0);

    // Yellow counts 2, 1, 1 then clears once the light goes red.
    idle(3'b010, 4);
    checkOutput("yellow2", 32'(yellow_time), 32'd2);
    idle(3'b010, 4);
    checkOutput("yellow1", 32'(yellow_time), 32'd1);
    idle(3'b010, 4);
    checkOutput("yellow_hold1", 32'(yellow_time), 32'd1);
    idle(3'b001, 1);
    checkOutput("yellow_clr", 32'(yellow_time), 32'd0);

    // Rejected write flags for one cycle and keeps the durations.
    applyStimulus(1'b0, 3'b001, 1'b1, 6'd30, 6'd3);
    applyStimulus(1'b0, 3'b001, 1'b1, 6'd0, 6'd5);
    checkOutput("err_pulse", 32'(cfg_err), 32'd1);
    idle(3'b001, 1);
    checkOutput("err_gone", 32'(cfg_err), 32'd0);
    applyStimulus(1'b1, 3'b001, 1'b0, 6'd0, 6'd0);
    checkOutput("load_after_rej", 32'(green_time), 32'd30);

    // Write coinciding with restart uses the old value, next restart the new.
    applyStimulus(1'b1, 3'b001, 1'b1, 6'd10, 6'd2);
    checkOutput("load_old", 32'(green_time), 32'd30);
    idle(3'b100, 1);
    applyStimulus(1'b1, 3'b001, 1'b0, 6'd0, 6'd0);
    checkOutput("load_new", 32'(green_time), 32'd10);

    // Reset in the middle of a green count abandons it.
    applyStimulus(1'b0, 3'b100, 1'b1, 6'd17, 6'd3);
    applyStimulus(1'b1, 3'b001, 1'b0, 6'd0, 6'd0);
    idle(3'b100, 1);
    checkOutput("green17", 32'(green_time), 32'd17);
    doReset();
    idle(3'b100, 8);
    checkOutput("post_rst_green", 32'(green_time), 32'd0);

    // Randomized traffic against the model, with periodic resets.
    for (int blk = 0; blk < 3; blk++) begin
      for (int i = 0; i < 150; i++) begin
        logic [2:0] lt;
        logic       st;
        logic       we;
        logic [5:0] cg;
        logic [5:0] cy;
        int r;
        r = int'($urandom_range(0, 9));
        if (r <= 2) lt = 3'b100;
        else if (r <= 5) lt = 3'b010;
        else if (r <= 8) lt = 3'b001;
        else lt = 3'($urandom_range(0, 7));
        st = ($urandom_range(0, 5) == 0);
        we = ($urandom_range(0, 9) == 0);
        cg = ($urandom_range(0, 6) == 0) ? 6'd0 : 6'($urandom_range(1, 6));
        cy = ($urandom_range(0, 6) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
        applyStimulus(st, lt, we, cg, cy);
      end
      doReset();
    end

    $display("[TB] stimulus complete");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
